// File: rtl/char_buf_pkg.sv
// Shared definitions for the writable 16x16 character buffer.
// Holds the grid geometry, the special character codes, the writer FSM
// state type and the packed cursor type ({row, col} == buffer address).
package char_buf_pkg;

  localparam int COLS   = 16;
  localparam int ROWS   = 16;
  localparam int CODE_W = 7;
  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int ADDR_W = COL_W + ROW_W;
  localparam int DEPTH  = COLS * ROWS;

  localparam logic [CODE_W-1:0] CODE_NEWLINE = 7'h0A;
  localparam logic [CODE_W-1:0] CODE_SPACE   = 7'h20;

  // Last address visited by the clear sweep.
  localparam logic [ADDR_W-1:0] CLEAR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Packing row above col makes the struct usable directly as a RAM address.
  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } cursor_t;

endpackage

// File: rtl/char_buffer_ram.sv
// 256x7 simple dual-port character RAM.
// Ports:
//   clk      - clock
//   rst      - sync active-high reset, clears only the read data register
//   i_we     - write enable
//   i_waddr  - write address {row, col}
//   i_wdata  - write data (character code)
//   i_raddr  - read address {row, col}
//   o_rdata  - registered read data, one cycle after i_raddr
// The array itself has no reset so it maps onto block RAM. A read and a
// write to the same address in one cycle return the old contents.
module char_buffer_ram
  import char_buf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [CODE_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [CODE_W-1:0] o_rdata
);

  logic [CODE_W-1:0] r_mem [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port; sees pre-write contents on an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rdata <= '0;
    end else begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/char_buffer_writer.sv
// Writer end of the character grid used by the text renderers.
// Ports:
//   clk        - system (pixel) clock
//   rst        - sync active-high reset; aborts a clear in progress
//   clear_req  - pulse: fill the whole buffer with FILL_CODE
//   cursor_set - pulse: load cursor from cursor_xy
//   cursor_xy  - new cursor {row, col}
//   wr_valid   - character write request
//   wr_code    - character code to write
//   wr_ready   - write accepted when wr_valid && wr_ready (combinational)
//   busy       - clear sweep in progress
//   cursor     - current cursor {row, col}
//   char_xy    - renderer read address {row, col}
//   char_code  - code at char_xy, one cycle later
module char_buffer_writer
  import char_buf_pkg::*;
#(
  parameter logic [CODE_W-1:0] FILL_CODE = CODE_SPACE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  input  logic              cursor_set,
  input  logic [ADDR_W-1:0] cursor_xy,
  input  logic              wr_valid,
  input  logic [CODE_W-1:0] wr_code,
  output logic              wr_ready,
  output logic              busy,
  output logic [ADDR_W-1:0] cursor,
  input  logic [ADDR_W-1:0] char_xy,
  output logic [CODE_W-1:0] char_code
);

  state_t            r_state;
  cursor_t           r_cursor;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_busy;

  logic              w_accept;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [CODE_W-1:0] w_wdata;

  assign wr_ready = (r_state == IDLE) && !clear_req && !cursor_set;
  assign w_accept = wr_valid && wr_ready;
  assign busy     = r_busy;
  assign cursor   = r_cursor;

  // RAM write mux: the clear sweep owns the port while in CLEAR. Writes are
  // gated by rst so an aborted clear does not touch the address it was on.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_cursor;
    w_wdata = wr_code;
    if (rst) begin
      w_we = 1'b0;
    end else if (r_state == CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_clr_cnt;
      w_wdata = FILL_CODE;
    end else begin
      w_we = w_accept && (wr_code != CODE_NEWLINE);
    end
  end

  // Control FSM: clear sweep, cursor load and cursor advance on writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cursor  <= '0;
      r_clr_cnt <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clear_req) begin
            r_state   <= CLEAR;
            r_busy    <= 1'b1;
            r_clr_cnt <= '0;
          end else if (cursor_set) begin
            r_cursor <= cursor_t'(cursor_xy);
          end else if (wr_valid) begin
            if (wr_code == CODE_NEWLINE) begin
              r_cursor.col <= '0;
              r_cursor.row <= r_cursor.row + 4'd1;
            end else begin
              // {row, col} + 1 gives col wrap into the next row and the
              // bottom-right to top-left wrap in one add.
              r_cursor <= cursor_t'(r_cursor + 8'd1);
            end
          end else begin
            r_cursor <= r_cursor;
          end
        end
        CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 8'd1;
          if (r_clr_cnt == CLEAR_LAST) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_cursor <= '0;
          end else begin
            r_state <= CLEAR;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  char_buffer_ram u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (char_xy),
    .o_rdata (char_code)
  );

endmodule

// File: tb/tb_char_buffer_writer.sv
// Directed bench for char_buffer_writer with hand-computed expectations.
module tb_char_buffer_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear_req;
  logic       cursor_set;
  logic [7:0] cursor_xy;
  logic       wr_valid;
  logic [6:0] wr_code;
  logic       wr_ready;
  logic       busy;
  logic [7:0] cursor;
  logic [7:0] char_xy;
  logic [6:0] char_code;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  char_buffer_writer dut (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (clear_req),
    .cursor_set (cursor_set),
    .cursor_xy  (cursor_xy),
    .wr_valid   (wr_valid),
    .wr_code    (wr_code),
    .wr_ready   (wr_ready),
    .busy       (busy),
    .cursor     (cursor),
    .char_xy    (char_xy),
    .char_code  (char_code)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cursor(input logic [7:0] xy);
    cursor_set = 1'b1;
    cursor_xy  = xy;
    tick();
    cursor_set = 1'b0;
  endtask

  task automatic put(input logic [6:0] code);
    wr_valid = 1'b1;
    wr_code  = code;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [6:0] d);
    char_xy = a;
    tick();
    d = char_code;
  endtask

  logic [6:0] d;
  int         cyc;
  logic       ready_seen;

  initial begin
    rst = 1'b1; clear_req = 1'b0; cursor_set = 1'b0; cursor_xy = 8'h00;
    wr_valid = 1'b0; wr_code = 7'h00; char_xy = 8'h00;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_cursor", cursor, 8'h00);
    chk("rst_char_code", char_code, 7'h00);
    chk("rst_ready", wr_ready, 1'b1);
    rst = 1'b0;

    // Full clear, with cursor_set and writes held high to prove they are ignored.
    clear_req = 1'b1;
    #1;
    chk("ready_low_on_clear_req", wr_ready, 1'b0);
    tick();
    clear_req = 1'b0;
    cursor_set = 1'b1; cursor_xy = 8'h55; wr_valid = 1'b1; wr_code = 7'h58;
    cyc = 0; ready_seen = 1'b0;
    while (busy && cyc < 400) begin
      if (wr_ready) ready_seen = 1'b1;
      tick();
      cyc++;
    end
    cursor_set = 1'b0; wr_valid = 1'b0;
    chk("clear_busy_cycles", cyc, 256);
    chk("clear_ready_low", ready_seen, 1'b0);
    chk("clear_cursor", cursor, 8'h00);
    for (int a = 0; a < 256; a++) begin
      rd(a[7:0], d);
      chk($sformatf("clear_fill_%02h", a), d, 7'h20);
    end

    // Back-to-back stream across a row boundary.
    set_cursor(8'h3E);
    chk("cursor_set_3e", cursor, 8'h3E);
    wr_valid = 1'b1; wr_code = 7'h41;
    #1;
    chk("ready_idle", wr_ready, 1'b1);
    tick(); wr_code = 7'h42;
    tick(); wr_code = 7'h43;
    tick(); wr_valid = 1'b0;
    chk("stream_cursor", cursor, 8'h41);
    rd(8'h3E, d); chk("mem_3e", d, 7'h41);
    rd(8'h3F, d); chk("mem_3f", d, 7'h42);
    rd(8'h40, d); chk("mem_40", d, 7'h43);

    // Newline handling.
    set_cursor(8'h25);
    put(7'h0A);
    chk("newline_cursor", cursor, 8'h30);
    rd(8'h25, d); chk("newline_no_store", d, 7'h20);
    set_cursor(8'hF7);
    put(7'h0A);
    chk("newline_wrap", cursor, 8'h00);

    // Bottom-right write wraps to origin.
    set_cursor(8'hFF);
    put(7'h5A);
    chk("wrap_cursor", cursor, 8'h00);
    rd(8'hFF, d); chk("mem_ff", d, 7'h5A);

    // Seed data either side of the abort point.
    set_cursor(8'h63);
    put(7'h61);
    put(7'h62);
    chk("seed_cursor", cursor, 8'h65);

    // All three requests together: clear wins, no write, no cursor load.
    clear_req = 1'b1; cursor_set = 1'b1; cursor_xy = 8'h77;
    wr_valid = 1'b1; wr_code = 7'h33;
    #1;
    chk("ready_low_combo", wr_ready, 1'b0);
    tick();
    clear_req = 1'b0; cursor_set = 1'b0; wr_valid = 1'b0;
    chk("combo_busy", busy, 1'b1);
    chk("combo_cursor", cursor, 8'h65);
    for (int i = 0; i < 100; i++) tick();
    chk("abort_still_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    chk("abort_busy", busy, 1'b0);
    chk("abort_cursor", cursor, 8'h00);
    chk("abort_ready", wr_ready, 1'b1);
    rst = 1'b0;
    for (int a = 0; a < 100; a++) begin
      rd(a[7:0], d);
      chk($sformatf("abort_cleared_%02h", a), d, 7'h20);
    end
    rd(8'h64, d); chk("abort_keep_64", d, 7'h62);
    rd(8'h65, d); chk("combo_no_write_65", d, 7'h20);
    rd(8'hFF, d); chk("abort_keep_ff", d, 7'h5A);

    // Read-before-write on a same-address collision.
    set_cursor(8'h12);
    char_xy = 8'h12;
    wr_valid = 1'b1; wr_code = 7'h51;
    tick();
    wr_valid = 1'b0;
    chk("rbw_old", char_code, 7'h20);
    tick();
    chk("rbw_new", char_code, 7'h51);
    chk("rbw_cursor", cursor, 8'h13);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/char_buffer_writer.md
Name: char_buffer_writer

Overview:
Writer end of the character-grid interface used by the text renderers. Game/control logic streams 7-bit character codes into a 16x16 text buffer through a valid/ready port, with cursor positioning, newline handling and a bulk-clear sequence. The renderer side reads the same buffer via char_xy -> char_code. This block replaces the fixed per-screen char ROMs with a writable screen.

Parameters:
COLS, 16, characters per row (power of two)
ROWS, 16, rows in buffer (power of two)
CODE_W, 7, character code width
FILL_CODE, 7'h20, code written by clear (space)

Ports:
clk  in  1  system clock (pixel clock domain)
rst  in  1  synchronous active-high reset
clear_req  in  1  pulse: fill whole buffer with FILL_CODE
cursor_set  in  1  pulse: load cursor from cursor_xy
cursor_xy  in  8  new cursor, {row[3:0], col[3:0]}
wr_valid  in  1  character write request
wr_code  in  7  character code to write
wr_ready  out  1  write accepted when wr_valid && wr_ready
busy  out  1  clear sequence in progress
cursor  out  8  current cursor {row, col}
char_xy  in  8  renderer read address {row[3:0], col[3:0]}
char_code  out  7  code at char_xy, registered

Behaviour:
- Reset (sync, active-high): state IDLE, cursor 0, char_code 0, busy 0. Buffer contents are not reset. Reset during CLEAR aborts it; rows already cleared stay cleared.
- States: IDLE, CLEAR.
- IDLE priority: clear_req > cursor_set > write.
- wr_ready = (state==IDLE) && !clear_req && !cursor_set. This is combinational from the inputs.
- clear_req in IDLE: next cycle state CLEAR, busy=1, clear counter=0.
- CLEAR: each cycle writes FILL_CODE to mem[counter] and increments the counter. After address 255 is written, the next cycle enters IDLE with busy=0 and cursor=0. The sequence takes exactly 256 cycles with busy high. clear_req, cursor_set and writes are ignored while in CLEAR.
- cursor_set in IDLE (no clear_req): cursor <= cursor_xy on the next edge. No memory write.
- Accepted write, wr_code != 7'h0A:
  - mem[cursor] <= wr_code.
  - col increments. At col==15 it wraps to 0 and row increments.
  - At row==15, col==15 the cursor wraps to 0 (linear wrap).
- Accepted write, wr_code == 7'h0A (newline): nothing stored; col <= 0, row <= row+1 (mod 16).
- Throughput: one character per cycle in IDLE; no bubbles.
- Read port:
  - char_code <= mem[char_xy] every cycle, including during CLEAR. Latency 1 cycle; the renderer pipeline compensates.
  - Read and write to the same address in the same cycle returns the old data (read-before-write).
- Address mapping: mem index = {row, col} = char_xy, identical to the existing char ROM addressing, so font_rom addr = {char_code, char_line} is unchanged.
- cursor output reflects the registered cursor (post-update, visible the cycle after the event).

Decomposition:
- Package char_buf_pkg:
  - COLS, ROWS, CODE_W
  - CODE_NEWLINE = 7'h0A, CODE_SPACE = 7'h20
  - state enum {IDLE, CLEAR}
  - cursor struct {row[3:0], col[3:0]}
- Sub-module char_buffer_ram: 256x7 simple dual-port RAM, one sync write port and one registered read port, inferable as BRAM, no reset on the array.
- The FSM, cursor logic and handshake live in char_buffer_writer.

Test Plan:
- Reset, then clear_req pulse -> busy high for exactly 256 cycles, wr_ready=0 throughout, then cursor=8'h00; reading all 256 addresses returns 7'h20.
- cursor_set to 8'h3E, then stream 'A','B','C' back-to-back -> mem[8'h3E]=7'h41, mem[8'h3F]=7'h42, mem[8'h40]=7'h43; cursor=8'h41.
- cursor_set 8'h25, write 7'h0A -> cursor=8'h30, mem[8'h25] unchanged. At 8'hF7, a newline gives cursor=8'h00.
- cursor_set 8'hFF, write 'Z' -> mem[8'hFF]=7'h5A, cursor wraps to 8'h00.
- clear_req, cursor_set and wr_valid asserted together in IDLE -> CLEAR entered, no write, cursor ends at 8'h00. Also assert rst at clear cycle 100 -> state IDLE, busy=0, addresses 0..99 hold 7'h20, address 100+ keep old data.
- char_xy=8'h12 while writing 'Q' to 8'h12 -> char_code shows the old value next cycle and 7'h51 the cycle after.
